// File: rtl/ising_spin_update_pkg.sv
// Shared types and constants for the Ising spin-update sampler.
// Holds FSM encoding, LFSR polynomial and width helpers.
package ising_spin_update_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h80200003;
    localparam int          DEF_DATABITS = 32;

    // Width that holds field + noise without overflow.
    function automatic int sum_width(input int databits);
        return ((databits > 32) ? databits : 32) + 1;
    endfunction

    // One Galois step of x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ising_spin_update_if.sv
// Field/spin bus between the multiplier and the spin-update sampler.
// master drives fields and noise controls, slave returns spins.
interface ising_spin_update_if #(
    parameter int N         = 2,
    parameter int DATABITS  = 32,
    parameter int ITER_BITS = 16
);
    logic [DATABITS*N-1:0] field_in;
    logic                  field_valid;
    logic                  noise_en;
    logic [4:0]            noise_shift;
    logic [N-1:0]          spins;
    logic                  spins_valid;
    logic [DATABITS-1:0]   mm_start;
    logic                  busy;
    logic [ITER_BITS-1:0]  iter_count;

    modport master (
        output field_in, field_valid, noise_en, noise_shift,
        input  spins, spins_valid, mm_start, busy, iter_count
    );

    modport slave (
        input  field_in, field_valid, noise_en, noise_shift,
        output spins, spins_valid, mm_start, busy, iter_count
    );
endinterface

// File: rtl/ising_spin_update_lfsr.sv
// 32-bit Galois LFSR noise source, advanced only on step_i.
// A zero seed would lock up, so it is replaced by 1.
module ising_lfsr32
    import ising_spin_update_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_i,
    output logic [31:0] state_o
);
    localparam logic [31:0] INIT = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] state_q;

    // Advance one polynomial step per enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
        end else if (step_i) begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/ising_spin_update.sv
// Row-by-row spin sampler: field + LFSR noise, thresholded into
// a shadow vector that is committed to spins all at once.
module ising_spin_update
    import ising_spin_update_pkg::*;
#(
    parameter int           N         = 2,
    parameter int           DATABITS  = DEF_DATABITS,
    parameter logic [N-1:0] SPIN_INIT = '1,
    parameter logic [31:0]  SEED      = 32'h1,
    parameter int           ITER_BITS = 16
) (
    input logic                 clk,
    input logic                 rst,
    ising_spin_update_if.slave  bus_if
);
    localparam int SW = sum_width(DATABITS);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_e                state_q;
    logic [DATABITS*N-1:0] field_q;
    logic [N-1:0]          shadow_q;
    logic [N-1:0]          shadow_d;
    logic [N-1:0]          spins_q;
    logic [RW-1:0]         r_q;
    logic                  spins_valid_q;
    logic [DATABITS-1:0]   mm_start_q;
    logic                  busy_q;
    logic [ITER_BITS-1:0]  iter_q;

    logic [31:0]           lfsr_w;
    logic [31:0]           lfsr_nx;
    logic signed [31:0]    noise;
    logic [DATABITS-1:0]   h_r;
    logic [SW-1:0]         sum;

    ising_lfsr32 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_i  (state_q == ST_SAMPLE),
        .state_o (lfsr_w)
    );

    // Each row sees the LFSR word produced by this cycle's step.
    assign lfsr_nx = lfsr_step(lfsr_w);
    assign noise   = bus_if.noise_en
                   ? ($signed(lfsr_nx) >>> bus_if.noise_shift)
                   : 32'sd0;
    assign h_r     = field_q[int'(r_q)*DATABITS +: DATABITS];
    assign sum     = {{(SW-DATABITS){h_r[DATABITS-1]}}, h_r}
                   + {{(SW-32){noise[31]}}, noise};

    // Threshold current row into the shadow; a zero sum keeps the bit.
    always_comb begin
        shadow_d = shadow_q;
        if (sum != '0) begin
            shadow_d[r_q] = ~sum[SW-1];
        end
    end

    // Sampler FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            field_q       <= '0;
            shadow_q      <= '0;
            spins_q       <= SPIN_INIT;
            r_q           <= '0;
            spins_valid_q <= 1'b0;
            mm_start_q    <= '0;
            busy_q        <= 1'b0;
            iter_q        <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus_if.field_valid) begin
                        field_q <= bus_if.field_in;
                        busy_q  <= 1'b1;
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_q      <= '0;
                    shadow_q <= spins_q;
                    state_q  <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    shadow_q <= shadow_d;
                    if (r_q == LAST_ROW) begin
                        spins_q       <= shadow_d;
                        spins_valid_q <= 1'b1;
                        mm_start_q    <= DATABITS'(1);
                        iter_q        <= iter_q + 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_DONE;
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    spins_valid_q <= 1'b0;
                    mm_start_q    <= '0;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_if.spins       = spins_q;
    assign bus_if.spins_valid = spins_valid_q;
    assign bus_if.mm_start    = mm_start_q;
    assign bus_if.busy        = busy_q;
    assign bus_if.iter_count  = iter_q;
endmodule
